// File: rtl/lane_dly_move_sequencer.sv
// Purpose : sequences RX/TX DQS delay-line LOAD/MOVE strobes for one DDR4 byte lane,
//           wrapping every burst in an HS_IO_CLK_PAUSE window and aborting on out-of-range.
// Latency : accept in cycle 0, DONE at 1+PAUSE_SETUP+N*(1+MOVE_GAP)+RELEASE_HOLD
//           (cycle 1 for a zero-length move request).
// Backpr. : REQ_READY is high only in IDLE; REQ_VALID while not ready is dropped (no queueing).
//
// Ports (all in the FAB_CLK domain):
//   FAB_CLK, RESET                   clock, synchronous active-high reset
//   REQ_VALID/REQ_READY              request handshake
//   REQ_SEL/REQ_LOAD/REQ_DIR/REQ_TAPS  line select (0=RX,1=TX), load flag, direction (1=inc), strobe count
//   BUSY/DONE/ERR                    status; ERR is sticky until the next accept
//   RX/TX_DELAY_LINE_OUT_OF_RANGE    from LANECTRL
//   DELAY_LINE_SEL/LOAD/DIRECTION/MOVE, HS_IO_CLK_PAUSE  to LANECTRL
//   RX_TAP_POS/TX_TAP_POS            tap position trackers (only with LANE_DLY_TAP_TRACK_EN)
//
// Optional feature macro: LANE_DLY_TAP_TRACK_EN (adds saturating per-line tap position counters).

module lane_dly_move_sequencer #(
  parameter int TAP_W        = 8,
  parameter int PAUSE_SETUP  = 4,
  parameter int MOVE_GAP     = 2,
  parameter int RELEASE_HOLD = 4
) (
  input  logic             FAB_CLK,
  input  logic             RESET,
  input  logic             REQ_VALID,
  output logic             REQ_READY,
  input  logic             REQ_SEL,
  input  logic             REQ_LOAD,
  input  logic             REQ_DIR,
  input  logic [TAP_W-1:0] REQ_TAPS,
  output logic             BUSY,
  output logic             DONE,
  output logic             ERR,
  input  logic             RX_DELAY_LINE_OUT_OF_RANGE,
  input  logic             TX_DELAY_LINE_OUT_OF_RANGE,
  output logic             DELAY_LINE_SEL,
  output logic             DELAY_LINE_LOAD,
  output logic             DELAY_LINE_DIRECTION,
  output logic             DELAY_LINE_MOVE,
`ifdef LANE_DLY_TAP_TRACK_EN
  output logic [TAP_W-1:0] RX_TAP_POS,
  output logic [TAP_W-1:0] TX_TAP_POS,
`endif
  output logic             HS_IO_CLK_PAUSE
);

  // One shared phase timer serves PAUSE, GAP and RELEASE; size it for the longest phase.
  localparam int MAX_A = (PAUSE_SETUP > MOVE_GAP) ? PAUSE_SETUP : MOVE_GAP;
  localparam int MAX_B = (MAX_A > RELEASE_HOLD) ? MAX_A : RELEASE_HOLD;
  localparam int TMR_W = (MAX_B < 2) ? 1 : $clog2(MAX_B);

  localparam logic [TMR_W-1:0] PAUSE_LAST   = TMR_W'(PAUSE_SETUP - 1);
  localparam logic [TMR_W-1:0] GAP_LAST     = TMR_W'(MOVE_GAP - 1);
  localparam logic [TMR_W-1:0] RELEASE_LAST = TMR_W'(RELEASE_HOLD - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_PAUSE   = 3'd1,
    S_STROBE  = 3'd2,
    S_GAP     = 3'd3,
    S_RELEASE = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  state_t             state_q, state_d;
  logic [TMR_W-1:0]   tmr_q, tmr_d;
  logic [TAP_W-1:0]   rem_q, rem_d;
  logic               sel_q, sel_d;
  logic               load_q, load_d;
  logic               dir_q, dir_d;
  logic               abort_q, abort_d;
  logic               err_q, err_d;
  logic               ready_c;
  logic               oor_sel;

  // Only the line being adjusted may abort the request.
  assign oor_sel = sel_q ? TX_DELAY_LINE_OUT_OF_RANGE : RX_DELAY_LINE_OUT_OF_RANGE;

  // Gating with RESET keeps READY low while reset is held, so it first rises
  // on the cycle after RESET drops.
  assign REQ_READY = ready_c & ~RESET;
  assign ERR       = err_q;

  always_ff @(posedge FAB_CLK) begin
    if (RESET) begin
      state_q <= S_IDLE;
      tmr_q   <= '0;
      rem_q   <= '0;
      sel_q   <= 1'b0;
      load_q  <= 1'b0;
      dir_q   <= 1'b0;
      abort_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      rem_q   <= rem_d;
      sel_q   <= sel_d;
      load_q  <= load_d;
      dir_q   <= dir_d;
      abort_q <= abort_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d              = state_q;
    tmr_d                = tmr_q;
    rem_d                = rem_q;
    sel_d                = sel_q;
    load_d               = load_q;
    dir_d                = dir_q;
    abort_d              = abort_q;
    err_d                = err_q;
    ready_c              = 1'b0;
    BUSY                 = 1'b0;
    DONE                 = 1'b0;
    DELAY_LINE_SEL       = 1'b0;
    DELAY_LINE_LOAD      = 1'b0;
    DELAY_LINE_DIRECTION = 1'b0;
    DELAY_LINE_MOVE      = 1'b0;
    HS_IO_CLK_PAUSE      = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        ready_c = 1'b1;
        if (REQ_VALID && !RESET) begin
          sel_d   = REQ_SEL;
          load_d  = REQ_LOAD;
          dir_d   = REQ_DIR;
          abort_d = 1'b0;
          err_d   = 1'b0;
          tmr_d   = '0;
          // A load is always exactly one strobe regardless of REQ_TAPS.
          rem_d   = REQ_LOAD ? TAP_W'(1) : REQ_TAPS;
          if (!REQ_LOAD && (REQ_TAPS == '0)) begin
            state_d = S_DONE;
          end else begin
            state_d = S_PAUSE;
          end
        end
      end

      S_PAUSE: begin
        BUSY                 = 1'b1;
        HS_IO_CLK_PAUSE      = 1'b1;
        DELAY_LINE_SEL       = sel_q;
        DELAY_LINE_DIRECTION = dir_q;
        if (tmr_q == PAUSE_LAST) begin
          tmr_d   = '0;
          state_d = S_STROBE;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end

      S_STROBE: begin
        BUSY                 = 1'b1;
        HS_IO_CLK_PAUSE      = 1'b1;
        DELAY_LINE_SEL       = sel_q;
        DELAY_LINE_DIRECTION = dir_q;
        DELAY_LINE_LOAD      = load_q;
        DELAY_LINE_MOVE      = ~load_q;
        tmr_d                = '0;
        state_d              = S_GAP;
      end

      S_GAP: begin
        BUSY                 = 1'b1;
        HS_IO_CLK_PAUSE      = 1'b1;
        DELAY_LINE_SEL       = sel_q;
        DELAY_LINE_DIRECTION = dir_q;
        if (oor_sel) begin
          abort_d = 1'b1;
        end
        if (tmr_q == GAP_LAST) begin
          tmr_d = '0;
          // rem_q counts the strobe just issued, so 1 means it was the last one.
          rem_d = rem_q - TAP_W'(1);
          if (abort_q || oor_sel || (rem_q <= TAP_W'(1))) begin
            state_d = S_RELEASE;
          end else begin
            state_d = S_STROBE;
          end
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end

      S_RELEASE: begin
        BUSY                 = 1'b1;
        HS_IO_CLK_PAUSE      = 1'b1;
        DELAY_LINE_SEL       = sel_q;
        DELAY_LINE_DIRECTION = dir_q;
        if (tmr_q == RELEASE_LAST) begin
          tmr_d   = '0;
          err_d   = abort_q;
          state_d = S_DONE;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end

      S_DONE: begin
        BUSY    = 1'b1;
        DONE    = 1'b1;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

`ifdef LANE_DLY_TAP_TRACK_EN
  logic [TAP_W-1:0] rx_pos_q, rx_pos_d;
  logic [TAP_W-1:0] tx_pos_q, tx_pos_d;

  // Next position for one strobe: load clears, moves step by one and saturate at the ends.
  function automatic logic [TAP_W-1:0] step_pos(input logic [TAP_W-1:0] pos,
                                                input logic ld, input logic up);
    logic [TAP_W-1:0] nxt;
    nxt = pos;
    if (ld) begin
      nxt = '0;
    end else if (up) begin
      if (pos != '1) nxt = pos + TAP_W'(1);
    end else begin
      if (pos != '0) nxt = pos - TAP_W'(1);
    end
    return nxt;
  endfunction

  always_comb begin
    rx_pos_d = rx_pos_q;
    tx_pos_d = tx_pos_q;
    if (state_q == S_STROBE) begin
      if (sel_q) begin
        tx_pos_d = step_pos(tx_pos_q, load_q, dir_q);
      end else begin
        rx_pos_d = step_pos(rx_pos_q, load_q, dir_q);
      end
    end
  end

  always_ff @(posedge FAB_CLK) begin
    if (RESET) begin
      rx_pos_q <= '0;
      tx_pos_q <= '0;
    end else begin
      rx_pos_q <= rx_pos_d;
      tx_pos_q <= tx_pos_d;
    end
  end

  assign RX_TAP_POS = rx_pos_q;
  assign TX_TAP_POS = tx_pos_q;
`endif

endmodule

// File: tb/tb_lane_dly_move_sequencer.sv
// Bench for lane_dly_move_sequencer: directed requests, a timing model derived from the
// strobe/DONE cycle formulas, one per-cycle compare process, and literal pins per request.
module tb_lane_dly_move_sequencer;
  localparam int TAP_W = 8;
  localparam int P     = 4;
  localparam int G     = 2;
  localparam int R     = 4;

  logic             FAB_CLK   = 1'b0;
  logic             RESET     = 1'b1;
  logic             REQ_VALID = 1'b0;
  logic             REQ_SEL   = 1'b0;
  logic             REQ_LOAD  = 1'b0;
  logic             REQ_DIR   = 1'b0;
  logic [TAP_W-1:0] REQ_TAPS  = '0;
  logic             RX_OOR    = 1'b0;
  logic             TX_OOR    = 1'b0;
  logic             REQ_READY, BUSY, DONE, ERR;
  logic             DL_SEL, DL_LOAD, DL_DIR, DL_MOVE, PAUSE_O;
`ifdef LANE_DLY_TAP_TRACK_EN
  logic [TAP_W-1:0] RX_TAP_POS, TX_TAP_POS;
`endif

  lane_dly_move_sequencer #(
    .TAP_W(TAP_W), .PAUSE_SETUP(P), .MOVE_GAP(G), .RELEASE_HOLD(R)
  ) dut (
    .FAB_CLK                    (FAB_CLK),
    .RESET                      (RESET),
    .REQ_VALID                  (REQ_VALID),
    .REQ_READY                  (REQ_READY),
    .REQ_SEL                    (REQ_SEL),
    .REQ_LOAD                   (REQ_LOAD),
    .REQ_DIR                    (REQ_DIR),
    .REQ_TAPS                   (REQ_TAPS),
    .BUSY                       (BUSY),
    .DONE                       (DONE),
    .ERR                        (ERR),
    .RX_DELAY_LINE_OUT_OF_RANGE (RX_OOR),
    .TX_DELAY_LINE_OUT_OF_RANGE (TX_OOR),
    .DELAY_LINE_SEL             (DL_SEL),
    .DELAY_LINE_LOAD            (DL_LOAD),
    .DELAY_LINE_DIRECTION       (DL_DIR),
    .DELAY_LINE_MOVE            (DL_MOVE),
`ifdef LANE_DLY_TAP_TRACK_EN
    .RX_TAP_POS                 (RX_TAP_POS),
    .TX_TAP_POS                 (TX_TAP_POS),
`endif
    .HS_IO_CLK_PAUSE            (PAUSE_O)
  );

  always #5 FAB_CLK = ~FAB_CLK;

  int cyc = 0;
  always @(posedge FAB_CLK) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [8:0] outvec();
    return {REQ_READY, BUSY, DONE, ERR, DL_SEL, DL_LOAD, DL_DIR, DL_MOVE, PAUSE_O};
  endfunction

  // ---------------- model state ----------------
  bit m_valid  = 0;   // a request has been accepted since reset
  bit in_rst   = 1;   // compare process idles while RESET is driven
  bit prev_err = 0;   // ERR value owed before this request's DONE
  bit m_sel, m_load, m_dir, m_abort;
  int t0, m_n, m_done;
  int obs_done, obs_strobes;
  int m_rx_pos = 0;
  int m_tx_pos = 0;

  // Number of strobes issued, abort flag and DONE cycle, from the cycle formulas.
  // oor_from is the first cycle (relative to accept) the selected line reports out-of-range; 0 = never.
  function automatic void model_compute(input bit load, input int taps, input int oor_from);
    int total, s;
    m_abort = 0;
    m_n     = 0;
    if (!load && taps == 0) begin
      m_done = 1;
      return;
    end
    total = load ? 1 : taps;
    for (int k = 0; k < total; k++) begin
      m_n = k + 1;
      s   = 1 + P + k * (1 + G);
      if (oor_from > 0 && s + G >= oor_from) begin
        m_abort = 1;
        break;
      end
    end
    m_done = 1 + P + m_n * (1 + G) + R;
  endfunction

  // ---------------- compare process ----------------
  int         c_rel;
  bit         c_busy, c_mid, c_strobe, c_err;
  logic [8:0] c_exp;

  always @(negedge FAB_CLK) begin
    if (!in_rst) begin
      c_rel    = m_valid ? (cyc - t0) : 0;
      c_busy   = m_valid && c_rel >= 1 && c_rel <= m_done;
      c_mid    = c_busy && c_rel < m_done;
      c_strobe = 0;
      if (c_mid && c_rel >= 1 + P) begin
        if (((c_rel - 1 - P) % (1 + G)) == 0 && ((c_rel - 1 - P) / (1 + G)) < m_n) c_strobe = 1;
      end
      if (c_busy)                        c_err = (c_rel == m_done) && m_abort;
      else if (m_valid && c_rel > m_done) c_err = m_abort;
      else                               c_err = prev_err;
      c_exp = {!c_busy, c_busy, c_busy && (c_rel == m_done), c_err,
               c_mid && m_sel, c_strobe && m_load, c_mid && m_dir, c_strobe && !m_load, c_mid};
      chk("outputs{rdy,busy,done,err,sel,load,dir,move,pause}", outvec(), c_exp);
      if (DONE === 1'b1) obs_done = c_rel;
      if (DL_MOVE === 1'b1 || DL_LOAD === 1'b1) obs_strobes++;
`ifdef LANE_DLY_TAP_TRACK_EN
      chk("rx_tap_pos", RX_TAP_POS, m_rx_pos);
      chk("tx_tap_pos", TX_TAP_POS, m_tx_pos);
      if (c_strobe) begin
        if (m_sel) begin
          if (m_load) m_tx_pos = 0;
          else if (m_dir) m_tx_pos = (m_tx_pos < (1 << TAP_W) - 1) ? m_tx_pos + 1 : m_tx_pos;
          else m_tx_pos = (m_tx_pos > 0) ? m_tx_pos - 1 : 0;
        end else begin
          if (m_load) m_rx_pos = 0;
          else if (m_dir) m_rx_pos = (m_rx_pos < (1 << TAP_W) - 1) ? m_rx_pos + 1 : m_rx_pos;
          else m_rx_pos = (m_rx_pos > 0) ? m_rx_pos - 1 : 0;
        end
      end
`endif
    end
  end

  // ---------------- stimulus ----------------
  // Issues one request and runs it to two cycles past DONE. junk_at pulses REQ_VALID with
  // different fields mid-request; rst_at asserts RESET at that relative cycle instead.
  task automatic run_req(input bit sel, input bit load, input bit dir, input int taps,
                         input int rx_from, input int tx_from, input int junk_at, input int rst_at,
                         input int exp_done, input int exp_n, input bit exp_err);
    @(posedge FAB_CLK); #2;
    REQ_SEL   = sel;
    REQ_LOAD  = load;
    REQ_DIR   = dir;
    REQ_TAPS  = taps[TAP_W-1:0];
    REQ_VALID = 1'b1;
    prev_err  = m_valid ? m_abort : 1'b0;
    m_sel = sel; m_load = load; m_dir = dir;
    model_compute(load, taps, sel ? tx_from : rx_from);
    t0 = cyc; obs_done = -1; obs_strobes = 0; m_valid = 1;
    for (int r = 1; r <= m_done + 2; r++) begin
      @(posedge FAB_CLK); #2;
      REQ_VALID = (r == junk_at);
      if (r == junk_at) begin
        REQ_SEL = ~sel; REQ_DIR = ~dir; REQ_LOAD = 1'b0; REQ_TAPS = 8'd7;
      end
      RX_OOR = (rx_from > 0 && r >= rx_from);
      TX_OOR = (tx_from > 0 && r >= tx_from);
      if (rst_at != 0 && r == rst_at) begin
        RESET = 1'b1; in_rst = 1;
        @(posedge FAB_CLK); #2;
        @(negedge FAB_CLK);
        chk("outputs_in_reset", outvec(), 9'h000);
`ifdef LANE_DLY_TAP_TRACK_EN
        chk("rx_tap_in_reset", RX_TAP_POS, 0);
`endif
        @(posedge FAB_CLK); #2;
        RESET = 1'b0; RX_OOR = 1'b0; TX_OOR = 1'b0;
        m_valid = 0; prev_err = 0; m_rx_pos = 0; m_tx_pos = 0; in_rst = 0;
        @(negedge FAB_CLK);
        chk("ready_after_reset", REQ_READY, 1);
        chk("busy_after_reset", BUSY, 0);
        return;
      end
    end
    RX_OOR = 1'b0; TX_OOR = 1'b0;
    chk("done_cycle", obs_done, exp_done);
    chk("strobe_count", obs_strobes, exp_n);
    chk("err_after_done", ERR, exp_err);
  endtask

  initial begin
    RESET = 1'b1; in_rst = 1;
    repeat (3) @(posedge FAB_CLK);
    @(negedge FAB_CLK);
    chk("outputs_during_reset", outvec(), 9'h000);
    @(posedge FAB_CLK); #2;
    RESET = 1'b0; in_rst = 0;
    @(negedge FAB_CLK);
    chk("ready_first_cycle_after_reset", REQ_READY, 1);

    // RX move up 3: strobes 5,8,11; DONE 18.
    run_req(0, 0, 1, 3, 0, 0, 0, 0, 18, 3, 0);
    // TX load, TAPS ignored: one LOAD at 5; DONE 12.
    run_req(1, 1, 0, 9, 0, 0, 0, 0, 12, 1, 0);
    // RX move 5 with RX out-of-range from cycle 9: strobes 5,8; DONE 15; ERR sticky.
    run_req(0, 0, 1, 5, 9, 0, 0, 0, 15, 2, 1);
    // Zero-length: DONE at 1, no pause, ERR cleared.
    run_req(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    // RX move down 2 with TX out-of-range (ignored) and a stray REQ_VALID while busy.
    run_req(0, 0, 0, 2, 0, 2, 3, 0, 15, 2, 0);
    // Reset in cycle 7 of a TAPS=4 move.
    run_req(0, 0, 1, 4, 0, 0, 0, 7, 0, 0, 0);
    // Fresh request after reset behaves normally.
    run_req(1, 0, 1, 1, 0, 0, 0, 0, 12, 1, 0);

`ifdef LANE_DLY_TAP_TRACK_EN
    run_req(0, 1, 0, 9, 0, 0, 0, 0, 12, 1, 0);
    chk("rx_pos_after_load", RX_TAP_POS, 0);
    run_req(0, 0, 1, 3, 0, 0, 0, 0, 18, 3, 0);
    chk("rx_pos_after_up3", RX_TAP_POS, 3);
    run_req(0, 0, 0, 5, 0, 0, 0, 0, 24, 5, 0);
    chk("rx_pos_after_down5_saturated", RX_TAP_POS, 0);
    chk("tx_pos_after_rx_ops", TX_TAP_POS, 1);
`endif

    repeat (2) @(posedge FAB_CLK);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
